channel_sampler_multi: RTL
==========================

# channel_sampler_multi

Parametrised multi-channel sampler for the logic analyzer capture path, replacing the fixed two-channel, four-deep, negedge-sampled channel sampler. It synchronises NUM_CH asynchronous probe inputs into the system clock domain and samples them on an internally generated tick (programmable divider). It packs HIST consecutive samples per channel into one word and hands the word to the capture buffer over a valid/ready handshake. Per-channel edge pulses are produced for the trigger logic.

## Interface
- NUM_CH, 2: number of probe channels (≥1)
- HIST, 4: samples per packed word (≥2)
- SYNC_STAGES, 2: synchroniser depth (≥2)
- DIV_W, 8: width of sample-period divider
- clk  in  1  system clock; all logic on posedge clk
- rst  in  1  synchronous, active-high reset
- en  in  1  capture enable
- div  in  DIV_W  sample period minus one (tick every div+1 cycles)
- ch_in  in  NUM_CH  asynchronous probe inputs
- smpl  out  NUM_CH*HIST  packed sample word
- smpl_vld  out  1  smpl holds an unaccepted word
- smpl_rdy  in  1  consumer accepts word when smpl_vld & smpl_rdy
- ch_q  out  NUM_CH  most recent sampled value per channel
- rise, fall  out  NUM_CH each  one-cycle edge pulses per channel
- ovr  out  1  sticky overrun flag
- ovr_clr  in  1  clears ovr

## Operation
- Reset: every flop, including synchroniser stages, cleared; all outputs 0.
- Synchroniser: SYNC_STAGES flops per channel; ch_sync = last stage.
- Divider: cnt counts 0..div, wraps to 0; tick = en & (cnt == div). div=0 gives tick every cycle. div changed mid-run takes effect at next compare; if cnt > new div, cnt runs to max (2^DIV_W−1), wraps to 0.
- On tick: hist <= {ch_sync, hist[NUM_CH*HIST-1:NUM_CH]} (newest sample in most-significant slot; within a slot channel NUM_CH−1 is MSB); ch_q <= ch_sync; pcnt increments 0..HIST−1.
- Word completion: tick with pcnt == HIST−1 → pcnt <= 0; completed word = {ch_sync, hist[NUM_CH*HIST-1:NUM_CH]}.
  - slot free (smpl_vld=0, or smpl_vld & smpl_rdy this cycle): smpl <= word, smpl_vld <= 1.
  - slot busy (smpl_vld & ~smpl_rdy): word dropped, smpl unchanged, ovr <= 1.
- Accept without completion: smpl_vld & smpl_rdy → smpl_vld <= 0; smpl holds last value.
- Edges: prev_ok flag set by first tick after en rises. On tick with prev_ok=1: rise <= ch_sync & ~ch_q, fall <= ~ch_sync & ch_q; otherwise rise/fall <= 0. No edges on first sample.
- en low: cnt, pcnt, prev_ok forced 0; hist and ch_q hold; partial word discarded; pending smpl/smpl_vld retained and handshake still works.
- ovr: set per above; cleared by ovr_clr; set wins if same cycle.
- rst mid-operation: everything cleared next edge, pending word lost.

## Timing
- ch_in change visible at ch_sync after SYNC_STAGES clock edges.
- First tick div+1 cycles after en first seen high.
- ch_q, rise, fall, hist update the cycle after tick; rise/fall are exactly one cycle wide.
- smpl_vld asserts the cycle after the completing tick; word rate one per HIST*(div+1) cycles.
- Continuous smpl_rdy=1: no overrun at any div including 0.

## Test plan
- Reset: assert rst with en=1, toggling inputs → all outputs 0, smpl_vld=0, ovr=0.
- Packing (NUM_CH=2, HIST=4, div=0, smpl_rdy=1): ch_sync sequence 01,10,11,00 on four consecutive ticks → smpl=8'h39, smpl_vld high for one cycle.
- Divider: div=3, ch_in[0] toggled every 2 cycles → ticks exactly every 4 cycles, ch_q[0] constant within run, smpl_vld once per 16 cycles.
- Edges: ch_in=00→01→11→10 on successive ticks (div=0) → rise=00,01,10,00 and fall=00,00,00,01; first sample after en rise gives no pulse.
- Backpressure: smpl_rdy=0 for 2 word periods → first word held, second dropped, ovr=1; smpl_rdy=1 then ovr_clr → ovr=0, next word flows.
- en drop mid-word: en low after 2 of 4 ticks, high again → next word contains only 4 fresh samples; pending word preserved.

Source files
------------

// File: rtl/channel_sampler_multi.sv
// Multi-channel probe sampler: synchronise, tick-sample, pack HIST samples/channel, edge pulses.
// Latency: SYNC_STAGES edges to ch_sync; ch_q/rise/fall/hist one cycle after tick; smpl_vld one cycle after completing tick.
// Backpressure: one-word output slot; a completed word arriving while the slot is unaccepted is dropped and sets ovr.
module channel_sampler_multi #(
    parameter int NUM_CH      = 2,
    parameter int HIST        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DIV_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [DIV_W-1:0]       div,
    input  logic [NUM_CH-1:0]      ch_in,
    output logic [NUM_CH*HIST-1:0] smpl,
    output logic                   smpl_vld,
    input  logic                   smpl_rdy,
    output logic [NUM_CH-1:0]      ch_q,
    output logic [NUM_CH-1:0]      rise,
    output logic [NUM_CH-1:0]      fall,
    output logic                   ovr,
    input  logic                   ovr_clr
);

    localparam int WW = NUM_CH * HIST;
    localparam int PW = (HIST > 2) ? $clog2(HIST) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(HIST - 1);

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] ch_sync;
    logic [DIV_W-1:0]  cnt;
    logic [PW-1:0]     pcnt;
    logic [WW-1:0]     hist;
    logic [WW-1:0]     word;
    logic              prev_ok;
    logic              tick;
    logic              word_done;
    logic              slot_free;
    logic              accept;

    assign ch_sync   = sync_q[SYNC_STAGES-1];
    assign tick      = en & (cnt == div);
    assign word      = {ch_sync, hist[WW-1:NUM_CH]};
    assign word_done = tick & (pcnt == PCNT_LAST);
    assign accept    = smpl_vld & smpl_rdy;
    // The slot is free if empty or being drained this very cycle, so a
    // continuously ready consumer never sees an overrun.
    assign slot_free = ~smpl_vld | smpl_rdy;

    // Metastability synchroniser chain per channel, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= ch_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Sample-period divider; a cnt above a freshly lowered div free-runs to wrap.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    // Sample shift register, last value, edge pulses and slot position counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt    <= '0;
            hist    <= '0;
            ch_q    <= '0;
            prev_ok <= 1'b0;
            rise    <= '0;
            fall    <= '0;
        end else if (!en) begin
            // Partial word is abandoned; hist/ch_q simply hold.
            pcnt    <= '0;
            prev_ok <= 1'b0;
            rise    <= '0;
            fall    <= '0;
        end else if (tick) begin
            hist    <= word;
            ch_q    <= ch_sync;
            prev_ok <= 1'b1;
            pcnt    <= (pcnt == PCNT_LAST) ? '0 : pcnt + PW'(1);
            if (prev_ok) begin
                rise <= ch_sync & ~ch_q;
                fall <= ~ch_sync & ch_q;
            end else begin
                rise <= '0;
                fall <= '0;
            end
        end else begin
            rise <= '0;
            fall <= '0;
        end
    end

    // Output word slot with valid/ready handshake; runs regardless of en.
    always_ff @(posedge clk) begin
        if (rst) begin
            smpl     <= '0;
            smpl_vld <= 1'b0;
        end else if (word_done && slot_free) begin
            smpl     <= word;
            smpl_vld <= 1'b1;
        end else if (accept) begin
            smpl_vld <= 1'b0;
        end
    end

    // Sticky overrun: a dropped word beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr <= 1'b0;
        end else if (word_done && !slot_free) begin
            ovr <= 1'b1;
        end else if (ovr_clr) begin
            ovr <= 1'b0;
        end
    end

endmodule
